// File: rtl/aes_round_sequencer_if.sv
// Handshake and round-datapath bundle between the AES round sequencer and its
// block source/sink, key expansion and shared combinational round logic.
interface aes_round_sequencer_if #(
    parameter int ROUND_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [127:0]       data_in;
    logic [127:0]       key_in;
    logic [127:0]       round_key;
    logic [127:0]       round_state;
    logic [127:0]       round_result;
    logic [ROUND_W-1:0] round;
    logic               mix_bypass;
    logic               key_step;
    logic               out_valid;
    logic               out_ready;
    logic [127:0]       data_out;
    logic               abort;
    logic               busy;

    modport slave (
        input  in_valid, data_in, key_in, round_key, round_result, out_ready, abort,
        output in_ready, round_state, round, mix_bypass, key_step, out_valid, data_out, busy
    );

    modport master (
        output in_valid, data_in, key_in, round_key, round_result, out_ready, abort,
        input  in_ready, round_state, round, mix_bypass, key_step, out_valid, data_out, busy
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round controller: owns the cipher state and round counter and
// steps one shared round datapath through rounds 1..NR, bypassing MixColumns on round NR.
module aes_round_sequencer #(
    parameter int NR      = 10,
    parameter int ROUND_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    aes_round_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seqState_t;

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NR);
    localparam logic [ROUND_W-1:0] ROUND_ZERO = {ROUND_W{1'b0}};
    localparam logic [ROUND_W-1:0] ROUND_ONE  = ROUND_W'(32'd1);

    seqState_t          fsm_r;
    seqState_t          fsmNext_s;
    logic [127:0]       state_r;
    logic [127:0]       stateNext_s;
    logic [ROUND_W-1:0] round_r;
    logic [ROUND_W-1:0] roundNext_s;
    logic               inReady_r;
    logic               outValid_r;
    logic               busy_r;
    logic               keyStep_r;
    logic               mixBypass_r;
    logic               inReadyNext_s;
    logic               outValidNext_s;
    logic               busyNext_s;
    logic               keyStepNext_s;
    logic               mixBypassNext_s;

    // Next FSM state, cipher state and round index.
    always_comb begin
        fsmNext_s   = fsm_r;
        stateNext_s = state_r;
        roundNext_s = round_r;
        case (fsm_r)
            IDLE: begin
                // abort wins over in_valid: nothing is captured that cycle
                if (bus.in_valid && !bus.abort) begin
                    stateNext_s = bus.data_in ^ bus.key_in;
                    roundNext_s = ROUND_ONE;
                    fsmNext_s   = RUN;
                end else begin
                    fsmNext_s = IDLE;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    fsmNext_s   = IDLE;
                    roundNext_s = ROUND_ZERO;
                end else if (round_r >= LAST_ROUND) begin
                    stateNext_s = bus.round_result;
                    roundNext_s = ROUND_ZERO;
                    fsmNext_s   = DONE;
                end else begin
                    stateNext_s = bus.round_result;
                    roundNext_s = round_r + ROUND_ONE;
                end
            end
            DONE: begin
                if (bus.abort || bus.out_ready) begin
                    fsmNext_s   = IDLE;
                    roundNext_s = ROUND_ZERO;
                end else begin
                    fsmNext_s = DONE;
                end
            end
            default: begin
                fsmNext_s   = IDLE;
                roundNext_s = ROUND_ZERO;
            end
        endcase
    end

    // Output flags are decoded from the next state so they can be registered.
    always_comb begin
        inReadyNext_s   = (fsmNext_s == IDLE);
        busyNext_s      = (fsmNext_s != IDLE);
        outValidNext_s  = (fsmNext_s == DONE);
        keyStepNext_s   = (fsmNext_s == RUN);
        mixBypassNext_s = (fsmNext_s == RUN) && (roundNext_s == LAST_ROUND);
    end

    // State, round counter and registered control outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_r       <= IDLE;
            state_r     <= 128'd0;
            round_r     <= ROUND_ZERO;
            inReady_r   <= 1'b1;
            outValid_r  <= 1'b0;
            busy_r      <= 1'b0;
            keyStep_r   <= 1'b0;
            mixBypass_r <= 1'b0;
        end else begin
            fsm_r       <= fsmNext_s;
            state_r     <= stateNext_s;
            round_r     <= roundNext_s;
            inReady_r   <= inReadyNext_s;
            outValid_r  <= outValidNext_s;
            busy_r      <= busyNext_s;
            keyStep_r   <= keyStepNext_s;
            mixBypass_r <= mixBypassNext_s;
        end
    end

    assign bus.in_ready    = inReady_r;
    assign bus.out_valid   = outValid_r;
    assign bus.busy        = busy_r;
    assign bus.key_step    = keyStep_r;
    assign bus.mix_bypass  = mixBypass_r;
    assign bus.round       = round_r;
    assign bus.round_state = state_r;
    assign bus.data_out    = state_r;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer with an attached AES round datapath and
// a key expansion model that advances only on key_step.
module tb_aes_round_sequencer;
    localparam int NR      = 10;
    localparam int ROUND_W = 4;

    logic clk = 1'b0;
    logic reset;
    int   nChecks = 0;
    int   nPass   = 0;
    logic [127:0] expQ[$];
    logic [127:0] keyReg;
    int           keyIdx;

    aes_round_sequencer_if #(.ROUND_W(ROUND_W)) bus ();
    aes_round_sequencer #(.NR(NR), .ROUND_W(ROUND_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box from first principles: GF(2^8) inverse (a^254) then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] t;
        inv = 8'h01;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) inv = gmul(inv, t);
            t = gmul(t, t);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aesRound(input logic [127:0] s, input logic [127:0] k,
                                              input logic lastRound);
        logic [127:0] sb;
        logic [127:0] sr;
        logic [127:0] mc;
        logic [7:0]   a0, a1, a2, a3;
        for (int i = 0; i < 16; i++) sb[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
        for (int c = 0; c < 4; c++) begin
            a0 = sr[127-32*c -: 8];
            a1 = sr[119-32*c -: 8];
            a2 = sr[111-32*c -: 8];
            a3 = sr[103-32*c -: 8];
            mc[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            mc[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            mc[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            mc[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        return (lastRound ? sr : mc) ^ k;
    endfunction

    function automatic logic [127:0] keyNext(input logic [127:0] k, input int idx);
        logic [7:0]  rc;
        logic [31:0] t;
        logic [31:0] w0, w1, w2, w3;
        rc = 8'h01;
        for (int i = 1; i < idx; i++) rc = xtime(rc);
        t  = {k[23:0], k[31:24]};
        t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h000000};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Whole-block reference: full key schedule up front, then NR rounds.
    function automatic logic [127:0] aesRef(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] rk[NR+1];
        logic [127:0] s;
        rk[0] = key;
        for (int r = 1; r <= NR; r++) rk[r] = keyNext(rk[r-1], r);
        s = pt ^ rk[0];
        for (int r = 1; r <= NR; r++) s = aesRound(s, rk[r], r == NR);
        return s;
    endfunction

    assign bus.round_key    = keyNext(keyReg, keyIdx + 1);
    assign bus.round_result = aesRound(bus.round_state, bus.round_key, bus.mix_bypass);

    // Key expansion model: loads the cipher key on accept, advances on key_step.
    always @(posedge clk) begin
        if (bus.in_valid && bus.in_ready && !bus.abort) begin
            keyReg <= bus.key_in;
            keyIdx <= 0;
        end else if (bus.key_step) begin
            keyReg <= bus.round_key;
            keyIdx <= keyIdx + 1;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Monitor: scoreboard push on accept, pop on output handshake, plus control invariants.
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready && !bus.abort && !reset) begin
            if (expQ.size() == 0) checkInt("scoreboardEmpty", expQ.size(), 1);
            else check("cipher", bus.data_out, expQ.pop_front());
        end
        if (reset || (bus.abort && bus.busy)) expQ.delete();
        else if (bus.in_valid && bus.in_ready && !bus.abort)
            expQ.push_back(aesRef(bus.data_in, bus.key_in));
        checkBit("roundMax", bus.round <= 4'(NR), 1'b1);
        checkBit("mixRule", bus.mix_bypass, bus.busy && !bus.out_valid && (bus.round == 4'(NR)));
        checkBit("keyStepRule", bus.key_step, bus.busy && !bus.out_valid);
        checkBit("readyRule", bus.in_ready, !bus.busy);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendBlock(input logic [127:0] d, input logic [127:0] k);
        int n;
        n = 0;
        bus.data_in  = d;
        bus.key_in   = k;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 40) begin
            tick();
            n++;
        end
        checkBit("acceptTimeout", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic waitOut();
        int n;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        checkBit("outValidTimeout", bus.out_valid, 1'b1);
    endtask

    task automatic waitRound(input int r);
        int n;
        n = 0;
        while (int'(bus.round) != r && n < 40) begin
            tick();
            n++;
        end
        checkInt("roundTimeout", int'(bus.round), r);
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int lat, mixCnt, mixAt, ksCnt, rdyCnt;
    int rounds[32];
    int acc1, acc2, hs1, hs2;
    logic [127:0] held;
    logic [127:0] d2, k2;

    initial begin
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.abort     = 1'b0;
        bus.data_in   = 128'd0;
        bus.key_in    = 128'd0;
        #1 reset = 1'b1;
        #3;
        checkBit("rstInReady", bus.in_ready, 1'b1);
        checkBit("rstOutValid", bus.out_valid, 1'b0);
        checkBit("rstBusy", bus.busy, 1'b0);
        checkBit("rstKeyStep", bus.key_step, 1'b0);
        checkBit("rstMix", bus.mix_bypass, 1'b0);
        checkInt("rstRound", int'(bus.round), 0);
        check("rstData", bus.data_out, 128'd0);
        #17 reset = 1'b0;
        tick();

        // FIPS-197 appendix B vector with a full control trace
        sendBlock(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        lat = 0; mixCnt = 0; mixAt = 0; ksCnt = 0; rdyCnt = 0;
        while (!bus.out_valid && lat < 30) begin
            rounds[lat] = int'(bus.round);
            if (bus.mix_bypass) begin
                mixCnt++;
                mixAt = int'(bus.round);
            end
            if (bus.key_step) ksCnt++;
            if (bus.in_ready) rdyCnt++;
            tick();
            lat++;
        end
        // out_valid appears after NR edges past the accepting edge
        checkInt("latency", lat, NR);
        for (int i = 0; i < NR; i++) checkInt("roundSeq", rounds[i], i + 1);
        checkInt("mixCount", mixCnt, 1);
        checkInt("mixRound", mixAt, NR);
        checkInt("keyStepCount", ksCnt, NR);
        checkInt("inReadyWhileRun", rdyCnt, 0);
        check("fipsCipher", bus.data_out, 128'h3925841d02dc09fbdc118597196a0b32);

        // Backpressure in DONE
        held = bus.data_out;
        for (int i = 0; i < 20; i++) begin
            check("bpData", bus.data_out, held);
            checkBit("bpValid", bus.out_valid, 1'b1);
            checkBit("bpInReady", bus.in_ready, 1'b0);
            tick();
        end
        take();
        checkBit("postHsValid", bus.out_valid, 1'b0);
        checkBit("postHsInReady", bus.in_ready, 1'b1);
        checkInt("postHsRound", int'(bus.round), 0);

        // Back-to-back with in_valid and out_ready held high
        d2 = rand128();
        k2 = rand128();
        bus.data_in   = rand128();
        bus.key_in    = rand128();
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        acc1 = -1; acc2 = -1; hs1 = -1; hs2 = -1;
        for (int n = 0; n < 60 && hs2 < 0; n++) begin
            if (bus.in_valid && bus.in_ready) begin
                if (acc1 < 0) acc1 = n;
                else if (acc2 < 0) acc2 = n;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (hs1 < 0) hs1 = n;
                else hs2 = n;
            end
            tick();
            if (acc1 >= 0 && acc2 < 0) begin
                bus.data_in = d2;
                bus.key_in  = k2;
            end
            if (acc2 >= 0) bus.in_valid = 1'b0;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checkBit("b2bSecondDone", hs2 >= 0, 1'b1);
        checkInt("b2bAcceptAfterHs", acc2 - hs1, 1);
        checkInt("b2bPeriod", acc2 - acc1, NR + 2);

        // Abort at round 5, then a clean block
        sendBlock(rand128(), rand128());
        waitRound(5);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checkInt("abortRound", int'(bus.round), 0);
        checkBit("abortBusy", bus.busy, 1'b0);
        checkBit("abortInReady", bus.in_ready, 1'b1);
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid) lat++;
            tick();
        end
        checkInt("abortNoOutValid", lat, 0);
        sendBlock(rand128(), rand128());
        waitOut();
        take();

        // Abort in IDLE blocks an offered block
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        bus.data_in  = rand128();
        tick();
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        checkBit("idleAbortNoAccept", bus.busy, 1'b0);

        // Abort together with out_ready in DONE
        sendBlock(rand128(), rand128());
        waitOut();
        bus.abort     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        checkBit("doneAbortValid", bus.out_valid, 1'b0);
        checkBit("doneAbortBusy", bus.busy, 1'b0);
        checkBit("doneAbortInReady", bus.in_ready, 1'b1);

        // Randomized blocks with random consumer stalls
        for (int b = 0; b < 6; b++) begin
            sendBlock(rand128(), rand128());
            waitOut();
            for (int s = 0; s < int'($urandom_range(0, 3)); s++) tick();
            take();
        end

        // Asynchronous reset between clock edges during RUN
        sendBlock(rand128(), rand128());
        waitRound(4);
        #2 reset = 1'b1;
        #1;
        checkInt("asyncRound", int'(bus.round), 0);
        checkBit("asyncBusy", bus.busy, 1'b0);
        checkBit("asyncInReady", bus.in_ready, 1'b1);
        checkBit("asyncOutValid", bus.out_valid, 1'b0);
        checkBit("asyncKeyStep", bus.key_step, 1'b0);
        check("asyncData", bus.data_out, 128'd0);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checkInt("postRstRound", int'(bus.round), 0);
        checkBit("postRstBusy", bus.busy, 1'b0);
        checkBit("postRstOutValid", bus.out_valid, 1'b0);
        check("postRstData", bus.data_out, 128'd0);
        sendBlock(rand128(), rand128());
        waitOut();
        take();

        tick();
        tick();
        checkInt("queueDrained", expQ.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
